// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard deframer delivering make-codes to the Memory key port
//   clock, reset        system clock, async active-high reset
//   ps2_clk, ps2_data   raw PS/2 lines, asynchronous to clock
//   key_reg             last accepted key code (held between keys)
//   sample              1-cycle pulse when key_reg updates
//   frame_err           1-cycle pulse when a frame is discarded (parity, stop, timeout)
//   busy                high while a frame is being received
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit FILTER_BREAK   = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_reg,
  output logic       sample,
  output logic       frame_err,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT_CYCLES - 1);
  typedef enum logic {IDLE, RECV} state_t;
  logic [1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic filt_q, filt_d, prev_q, prev_d;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, key_q, key_d;
  logic [WW-1:0] wd_q, wd_d;
  logic par_q, par_d, brk_q, brk_d, sample_q, sample_d, err_q, err_d;
  logic flip, fall, din, valid;
  // Filtered clock only toggles after FILTER_LEN consecutive opposite samples.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    flip = (clk_sync_q[1] != filt_q) && (fcnt_q == F_LAST);
    fcnt_d = (clk_sync_q[1] == filt_q || flip) ? '0 : fcnt_q + 1'b1;
    filt_d = flip ? ~filt_q : filt_q;
    prev_d = filt_q;
  end
  assign fall  = prev_q & ~filt_q;
  assign din   = dat_sync_q[1];
  assign valid = (^{shift_q, par_q}) & din;
  // cnt_q holds the index of the bit taken on the next fall: 1..8 data, 9 parity, 10 stop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    brk_d    = brk_q;
    key_d    = key_q;
    wd_d     = wd_q;
    sample_d = 1'b0;
    err_d    = 1'b0;
    if (state_q == IDLE) begin
      if (fall && !din) begin
        state_d = RECV;
        cnt_d   = 4'd1;
        wd_d    = '0;
      end
    end else if (fall) begin
      wd_d  = '0;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q <= 4'd8) shift_d = {din, shift_q[7:1]};
      else if (cnt_q == 4'd9) par_d = din;
      else begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!valid) err_d = 1'b1;
        else if (FILTER_BREAK && shift_q == 8'hF0) brk_d = 1'b1;
        else if (FILTER_BREAK && brk_q) brk_d = 1'b0;
        else begin
          key_d    = shift_q;
          sample_d = 1'b1;
        end
      end
    end else if (wd_q == W_LAST) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b1;
    end else wd_d = wd_q + 1'b1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      fcnt_q     <= '0;
      filt_q     <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= '0;
      wd_q       <= '0;
      sample_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      fcnt_q     <= fcnt_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      wd_q       <= wd_d;
      sample_q   <= sample_d;
      err_q      <= err_d;
    end
  end
  assign key_reg   = key_q;
  assign sample    = sample_q;
  assign frame_err = err_q;
  assign busy      = (state_q == RECV);
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: table, random and corner-case checks of ps2_key_receiver
module tb_ps2_key_receiver;
  localparam int HALF = 20;
  localparam int TMO  = 1000;
  logic clock = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] key_reg;
  logic sample, frame_err, busy;
  int checks = 0, errors = 0, tot_s = 0, tot_e = 0, tot_busy = 0;
  logic prev_s = 1'b0, prev_e = 1'b0;
  logic [7:0] m_key = 8'h00;
  bit m_brk = 1'b0;
  typedef struct {
    logic [7:0] d;
    bit bad;
    bit stop;
    int es;
    int ee;
    logic [7:0] ek;
  } vec_t;
  vec_t vecs[12];
  always #5 clock = ~clock;
  ps2_key_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO), .FILTER_BREAK(1'b1)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_reg(key_reg), .sample(sample), .frame_err(frame_err), .busy(busy)
  );
  always @(negedge clock) begin
    if (busy) tot_busy++;
    if (sample) tot_s++;
    if (frame_err) tot_e++;
    if (sample || frame_err) begin
      checks++;
      if ((sample && frame_err) || (sample && prev_s) || (frame_err && prev_e)) begin
        errors++;
        $display("FAIL pulse_shape: sample=%0b frame_err=%0b prev_sample=%0b prev_err=%0b, required single exclusive pulses",
                 sample, frame_err, prev_s, prev_e);
      end
    end
    prev_s = sample;
    prev_e = frame_err;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  function automatic logic [10:0] frame(input logic [7:0] d, input bit bad, input bit stop);
    return {stop, (~^d) ^ bad, d, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      ps2_data = b[i];
      repeat (HALF) @(posedge clock);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clock);
      ps2_clk = 1'b1;
    end
  endtask
  task automatic model(input logic [7:0] d, input bit bad, input bit stop, output int es, output int ee);
    es = 0;
    ee = 0;
    if (bad || !stop) ee = 1;
    else if (d == 8'hF0) m_brk = 1'b1;
    else if (m_brk) m_brk = 1'b0;
    else begin
      m_key = d;
      es = 1;
    end
  endtask
  task automatic run_frame(input string name, input logic [7:0] d, input bit bad, input bit stop,
                           input int es, input int ee, input logic [7:0] ek);
    int s0, e0;
    s0 = tot_s;
    e0 = tot_e;
    send_bits(frame(d, bad, stop), 11);
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk({name, "_samples"}, tot_s - s0, es);
    chk({name, "_errs"}, tot_e - e0, ee);
    chk({name, "_key"}, int'(key_reg), int'(ek));
    chk({name, "_busy"}, int'(busy), 0);
  endtask
  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int es, ee, s0, e0, b0;
    logic [7:0] d;
    bit bad, stop;
    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 0, 0, 8'h1C};
    vecs[3]  = '{8'h32, 1'b0, 1'b1, 1, 0, 8'h32};
    vecs[4]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h32};
    vecs[5]  = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h32};
    vecs[6]  = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0};
    vecs[7]  = '{8'hF0, 1'b0, 1'b1, 0, 0, 8'hE0};
    vecs[8]  = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'hE0};
    vecs[9]  = '{8'h5A, 1'b0, 1'b1, 0, 0, 8'hE0};
    vecs[10] = '{8'h00, 1'b0, 1'b1, 1, 0, 8'h00};
    vecs[11] = '{8'hFF, 1'b0, 1'b1, 1, 0, 8'hFF};
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_key", int'(key_reg), 0);
    chk("reset_sample", int'(sample), 0);
    chk("reset_err", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clock);
    reset = 1'b0;
    repeat (20) @(posedge clock);
    foreach (vecs[i])
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].bad, vecs[i].stop, vecs[i].es, vecs[i].ee, vecs[i].ek);
    m_key = 8'hFF;
    m_brk = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d    = ($urandom_range(0, 7) == 0) ? 8'hF0 : 8'($urandom);
      bad  = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 7) != 0);
      model(d, bad, stop, es, ee);
      run_frame($sformatf("rand%0d", i), d, bad, stop, es, ee, m_key);
    end
    e0 = tot_e;
    s0 = tot_s;
    send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
    for (int i = 0; i < TMO + 200 && tot_e == e0; i++) @(posedge clock);
    @(negedge clock);
    chk("timeout_err", tot_e - e0, 1);
    chk("timeout_samples", tot_s - s0, 0);
    chk("timeout_busy", int'(busy), 0);
    model(8'h32, 1'b0, 1'b1, es, ee);
    run_frame("after_timeout", 8'h32, 1'b0, 1'b1, es, ee, m_key);
    b0 = tot_busy;
    s0 = tot_s;
    e0 = tot_e;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      ps2_clk = 1'b0;
      repeat (3) @(posedge clock);
      ps2_clk = 1'b1;
      repeat (20) @(posedge clock);
    end
    repeat (20) @(posedge clock);
    @(negedge clock);
    chk("glitch_busy", tot_busy - b0, 0);
    chk("glitch_samples", tot_s - s0, 0);
    chk("glitch_errs", tot_e - e0, 0);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
    @(posedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_key", int'(key_reg), 0);
    chk("midreset_sample", int'(sample), 0);
    chk("midreset_err", int'(frame_err), 0);
    chk("midreset_busy", int'(busy), 0);
    @(posedge clock);
    @(posedge clock);
    reset = 1'b0;
    m_key = 8'h00;
    m_brk = 1'b0;
    s0 = tot_s;
    e0 = tot_e;
    repeat (50) @(posedge clock);
    @(negedge clock);
    chk("postreset_samples", tot_s - s0, 0);
    chk("postreset_errs", tot_e - e0, 0);
    model(8'h1C, 1'b0, 1'b1, es, ee);
    run_frame("after_reset", 8'h1C, 1'b0, 1'b1, es, ee, m_key);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
